demultiplexor_1in_2out: RTL and testbench

Routes a stream of 16-bit words from one producer to one of two consumers, chosen per word by `Sel`. It is the inverse of the team's 2-in/1-out data selector. Each output channel has its own 2-entry FIFO, so a stalled consumer does not block words bound for the other channel until its own buffer fills. Each channel also keeps a wrap-around count of routed words. It sits between the datapath result bus and the two register-file/memory write ports.

---
 rtl/demultiplexor_1in_2out.sv | 139 +++++++++++++
 tb/tb_demultiplexor_1in_2out.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexor_1in_2out.sv
// 1-to-2 word demultiplexer: routes each input word by Sel into one of two
// 2-entry FIFOs, each with its own wrap-around count of accepted words.

module demux_chan_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned DEPTH = 2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A pop with nothing buffered and a push into a full buffer are both no-ops.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    push_ok  = push && (occ_q != OCC_W'(DEPTH));
    pop_ok   = pop_req && (occ_q != OCC_W'(0));

    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
      count_d         = count_q + CNT_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (occ_q != OCC_W'(0));
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign count = count_q;

endmodule

module demultiplexor_1in_2out #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] DatoEntrada,
  input  logic             Sel,
  input  logic             EntradaValida,
  output logic             EntradaLista,
  output logic [WIDTH-1:0] SalidaA,
  output logic             ValidaA,
  input  logic             ListaA,
  output logic [WIDTH-1:0] SalidaB,
  output logic             ValidaB,
  input  logic             ListaB,
  output logic [7:0]       ContadorA,
  output logic [7:0]       ContadorB
);

  localparam int unsigned CNT_W = 8;

  logic full_a;
  logic full_b;
  logic push_a_c;
  logic push_b_c;

  // Ready depends only on the selected buffer's fill level, never on the consumer.
  always_comb begin
    EntradaLista = Sel ? !full_b : !full_a;
    push_a_c     = EntradaValida && !Sel && !full_a;
    push_b_c     = EntradaValida &&  Sel && !full_b;
  end

  demux_chan_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_a_c),
    .din     (DatoEntrada),
    .pop_req (ListaA),
    .dout    (SalidaA),
    .valid   (ValidaA),
    .full    (full_a),
    .count   (ContadorA)
  );

  demux_chan_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_b_c),
    .din     (DatoEntrada),
    .pop_req (ListaB),
    .dout    (SalidaB),
    .valid   (ValidaB),
    .full    (full_b),
    .count   (ContadorB)
  );

endmodule

// File: tb/tb_demultiplexor_1in_2out.sv
// Directed bench for demultiplexor_1in_2out with hand-computed expectations.

module tb_demultiplexor_1in_2out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] DatoEntrada;
  logic        Sel;
  logic        EntradaValida;
  logic        EntradaLista;
  logic [15:0] SalidaA;
  logic        ValidaA;
  logic        ListaA;
  logic [15:0] SalidaB;
  logic        ValidaB;
  logic        ListaB;
  logic [7:0]  ContadorA;
  logic [7:0]  ContadorB;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demultiplexor_1in_2out #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .DatoEntrada   (DatoEntrada),
    .Sel           (Sel),
    .EntradaValida (EntradaValida),
    .EntradaLista  (EntradaLista),
    .SalidaA       (SalidaA),
    .ValidaA       (ValidaA),
    .ListaA        (ListaA),
    .SalidaB       (SalidaB),
    .ValidaB       (ValidaB),
    .ListaB        (ListaB),
    .ContadorA     (ContadorA),
    .ContadorB     (ContadorB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    EntradaValida = v;
    Sel           = s;
    DatoEntrada   = d;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000);
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    ListaA  = 1'b1;
    ListaB  = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valida_a",  32'(ValidaA), 32'd0);
    chk("rst_valida_b",  32'(ValidaB), 32'd0);
    chk("rst_salida_a",  32'(SalidaA), 32'h0);
    chk("rst_salida_b",  32'(SalidaB), 32'h0);
    chk("rst_cnt_a",     32'(ContadorA), 32'd0);
    chk("rst_cnt_b",     32'(ContadorB), 32'd0);
    chk("rst_lista",     32'(EntradaLista), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_lista", 32'(EntradaLista), 32'd1);

    // Single words to A then B with both consumers ready.
    drive(1'b1, 1'b0, 16'h1234);
    chk("t1_lista_a", 32'(EntradaLista), 32'd1);
    step();
    drive(1'b1, 1'b1, 16'hABCD);
    chk("t1_valida_a", 32'(ValidaA), 32'd1);
    chk("t1_salida_a", 32'(SalidaA), 32'h1234);
    chk("t1_valida_b0", 32'(ValidaB), 32'd0);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("t1_valida_a_gone", 32'(ValidaA), 32'd0);
    chk("t1_valida_b", 32'(ValidaB), 32'd1);
    chk("t1_salida_b", 32'(SalidaB), 32'hABCD);
    step();
    chk("t1_valida_b_gone", 32'(ValidaB), 32'd0);
    chk("t1_cnt_a", 32'(ContadorA), 32'd1);
    chk("t1_cnt_b", 32'(ContadorB), 32'd1);

    // Backpressure: A stalled, third word held until space frees.
    do_reset();
    ListaA = 1'b0;
    drive(1'b1, 1'b0, 16'h0001);
    chk("t2_lista_w1", 32'(EntradaLista), 32'd1);
    step();
    drive(1'b1, 1'b0, 16'h0002);
    chk("t2_lista_w2", 32'(EntradaLista), 32'd1);
    step();
    drive(1'b1, 1'b0, 16'h0003);
    chk("t2_lista_full", 32'(EntradaLista), 32'd0);
    step();
    chk("t2_lista_held", 32'(EntradaLista), 32'd0);
    chk("t2_head_held", 32'(SalidaA), 32'h0001);
    chk("t2_cnt_held", 32'(ContadorA), 32'd2);
    ListaA = 1'b1;
    #1;
    chk("t2_full_while_pop", 32'(EntradaLista), 32'd0);
    step();
    chk("t2_drain1_valid", 32'(ValidaA), 32'd1);
    chk("t2_drain2", 32'(SalidaA), 32'h0002);
    chk("t2_lista_reopen", 32'(EntradaLista), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("t2_drain3", 32'(SalidaA), 32'h0003);
    chk("t2_drain3_valid", 32'(ValidaA), 32'd1);
    step();
    chk("t2_empty", 32'(ValidaA), 32'd0);
    chk("t2_cnt_a", 32'(ContadorA), 32'd3);

    // Channel independence: A full and stalled, B streams freely.
    do_reset();
    ListaA = 1'b0;
    ListaB = 1'b1;
    drive(1'b1, 1'b0, 16'h00A1);
    step();
    drive(1'b1, 1'b0, 16'h00A2);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 16'h00B0 + 16'(i));
      chk($sformatf("t3_lista_b%0d", i), 32'(EntradaLista), 32'd1);
      step();
      chk($sformatf("t3_valid_b%0d", i), 32'(ValidaB), 32'd1);
      chk($sformatf("t3_data_b%0d", i), 32'(SalidaB), 32'h00B0 + 32'(i));
    end
    drive(1'b0, 1'b0, 16'h0000);
    step();
    chk("t3_b_empty", 32'(ValidaB), 32'd0);
    chk("t3_a_valid", 32'(ValidaA), 32'd1);
    chk("t3_a_head", 32'(SalidaA), 32'h00A1);
    drive(1'b1, 1'b0, 16'h00FF);
    chk("t3_a_still_full", 32'(EntradaLista), 32'd0);
    drive(1'b0, 1'b0, 16'h0000);
    chk("t3_cnt_a", 32'(ContadorA), 32'd2);
    chk("t3_cnt_b", 32'(ContadorB), 32'd4);
    ListaA = 1'b1;
    step();
    chk("t3_a_second", 32'(SalidaA), 32'h00A2);
    step();
    chk("t3_a_drained", 32'(ValidaA), 32'd0);

    // Push and pop together at occupancy 1: one word per cycle, never stalling.
    do_reset();
    ListaA = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 16'h0100 + 16'(i));
      chk($sformatf("t4_lista%0d", i), 32'(EntradaLista), 32'd1);
      step();
      chk($sformatf("t4_valid%0d", i), 32'(ValidaA), 32'd1);
      chk($sformatf("t4_data%0d", i), 32'(SalidaA), 32'h0100 + 32'(i));
    end
    drive(1'b0, 1'b0, 16'h0000);
    step();
    chk("t4_empty", 32'(ValidaA), 32'd0);
    chk("t4_cnt_a", 32'(ContadorA), 32'd10);

    // Counter wrap on B.
    do_reset();
    ListaB = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 1'b1, 16'(i));
      step();
      if (i == 254) chk("t5_cnt_b_255", 32'(ContadorB), 32'd255);
      if (i == 255) chk("t5_cnt_b_wrap", 32'(ContadorB), 32'd0);
    end
    drive(1'b0, 1'b0, 16'h0000);
    chk("t5_cnt_b", 32'(ContadorB), 32'd1);
    chk("t5_cnt_a", 32'(ContadorA), 32'd0);
    chk("t5_last_b", 32'(SalidaB), 32'h0100);

    // Asynchronous reset with both FIFOs full.
    do_reset();
    ListaA = 1'b0;
    ListaB = 1'b0;
    drive(1'b1, 1'b0, 16'h0A01);
    step();
    drive(1'b1, 1'b0, 16'h0A02);
    step();
    drive(1'b1, 1'b1, 16'h0B01);
    step();
    drive(1'b1, 1'b1, 16'h0B02);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("t6_full_a_valid", 32'(ValidaA), 32'd1);
    chk("t6_full_b_valid", 32'(ValidaB), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_valida", 32'(ValidaA), 32'd0);
    chk("t6_async_validb", 32'(ValidaB), 32'd0);
    chk("t6_async_cnt_a", 32'(ContadorA), 32'd0);
    chk("t6_async_cnt_b", 32'(ContadorB), 32'd0);
    chk("t6_async_sal_a", 32'(SalidaA), 32'h0);
    chk("t6_async_lista", 32'(EntradaLista), 32'd1);
    step();
    reset_n = 1'b1;
    ListaA  = 1'b1;
    drive(1'b1, 1'b0, 16'h5A5A);
    step();
    drive(1'b0, 1'b0, 16'h0000);
    chk("t6_new_valid", 32'(ValidaA), 32'd1);
    chk("t6_new_data", 32'(SalidaA), 32'h5A5A);
    chk("t6_new_cnt", 32'(ContadorA), 32'd1);
    chk("t6_b_clear", 32'(ValidaB), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
